// File: rtl/riscv_core_reorder_buffer.sv
// Reorder buffer for the 2-wide in-order-issue core: allocates up to two
// slots per cycle in program order, accepts out-of-order writebacks from
// pipelines A and B, and retires up to two oldest completed entries per cycle
// as register-file write ports.
module riscv_core_reorder_buffer #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc0_req,
    input  logic             alloc0_dst_en,
    input  logic [4:0]       alloc0_dst,
    input  logic             alloc1_req,
    input  logic             alloc1_dst_en,
    input  logic [4:0]       alloc1_dst,
    output logic             alloc_rdy,
    output logic [IDX_W-1:0] alloc0_slot,
    output logic [IDX_W-1:0] alloc1_slot,
    input  logic             fillA_val,
    input  logic [IDX_W-1:0] fillA_slot,
    input  logic [31:0]      fillA_data,
    input  logic             fillB_val,
    input  logic [IDX_W-1:0] fillB_slot,
    input  logic [31:0]      fillB_data,
    output logic             commit0_val,
    output logic             commit0_wen,
    output logic [4:0]       commit0_waddr,
    output logic [31:0]      commit0_wdata,
    output logic             commit1_val,
    output logic             commit1_wen,
    output logic [4:0]       commit1_waddr,
    output logic [31:0]      commit1_wdata,
    output logic [IDX_W:0]   rob_count,
    output logic             rob_empty
);

    localparam int unsigned CNT_W = IDX_W + 1;

    logic [IDX_W-1:0]   head_q, head_d;
    logic [IDX_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] done_q, done_d;
    logic [ENTRIES-1:0] wen_q, wen_d;
    logic [4:0]         waddr_q [ENTRIES];
    logic [4:0]         waddr_d [ENTRIES];
    logic [31:0]        data_q  [ENTRIES];
    logic [31:0]        data_d  [ENTRIES];

    logic [IDX_W-1:0]   head1;
    logic               do_alloc0;
    logic               do_alloc1;
    logic [1:0]         n_alloc;
    logic [1:0]         n_ret;

    // Allocation and commit views, derived from registered state only
    assign head1         = head_q + IDX_W'(1);
    assign alloc_rdy     = (count_q <= CNT_W'(ENTRIES - 2));
    assign alloc0_slot   = tail_q;
    assign alloc1_slot   = tail_q + IDX_W'(1);
    assign do_alloc0     = alloc_rdy & alloc0_req;
    assign do_alloc1     = do_alloc0 & alloc1_req;
    assign n_alloc       = {1'b0, do_alloc0} + {1'b0, do_alloc1};

    assign commit0_val   = valid_q[head_q] & done_q[head_q];
    assign commit1_val   = commit0_val & valid_q[head1] & done_q[head1];
    assign commit0_wen   = commit0_val & wen_q[head_q];
    assign commit1_wen   = commit1_val & wen_q[head1];
    assign commit0_waddr = waddr_q[head_q];
    assign commit1_waddr = waddr_q[head1];
    assign commit0_wdata = data_q[head_q];
    assign commit1_wdata = data_q[head1];
    assign n_ret         = {1'b0, commit0_val} + {1'b0, commit1_val};

    assign rob_count     = count_q;
    assign rob_empty     = (count_q == '0);

    // Next state: fills (A after B so A wins), then retire, then allocate
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        wen_d   = wen_q;
        waddr_d = waddr_q;
        data_d  = data_q;
        head_d  = head_q + IDX_W'(n_ret);
        tail_d  = tail_q + IDX_W'(n_alloc);
        count_d = count_q + CNT_W'(n_alloc) - CNT_W'(n_ret);

        if (fillB_val && valid_q[fillB_slot]) begin
            done_d[fillB_slot] = 1'b1;
            data_d[fillB_slot] = fillB_data;
        end
        if (fillA_val && valid_q[fillA_slot]) begin
            done_d[fillA_slot] = 1'b1;
            data_d[fillA_slot] = fillA_data;
        end

        if (commit0_val) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        if (commit1_val) begin
            valid_d[head1] = 1'b0;
            done_d[head1]  = 1'b0;
        end

        if (do_alloc0) begin
            valid_d[alloc0_slot] = 1'b1;
            done_d[alloc0_slot]  = 1'b0;
            wen_d[alloc0_slot]   = alloc0_dst_en & (alloc0_dst != 5'd0);
            waddr_d[alloc0_slot] = alloc0_dst;
        end
        if (do_alloc1) begin
            valid_d[alloc1_slot] = 1'b1;
            done_d[alloc1_slot]  = 1'b0;
            wen_d[alloc1_slot]   = alloc1_dst_en & (alloc1_dst != 5'd0);
            waddr_d[alloc1_slot] = alloc1_dst;
        end
    end

    // Control state: pointers, occupancy and per-slot flags
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            wen_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            wen_q   <= wen_d;
        end
    end

    // Payload storage; only meaningful while the owning slot is valid
    always_ff @(posedge clk) begin
        waddr_q <= waddr_d;
        data_q  <= data_d;
    end

endmodule

// File: tb/tb_riscv_core_reorder_buffer.sv
// Bench for riscv_core_reorder_buffer: directed scenarios followed by random
// traffic, checked against a program-order queue model of the buffer.
module tb_riscv_core_reorder_buffer;

    localparam int unsigned ENTRIES = 16;
    localparam int unsigned IDX_W   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             alloc0_req, alloc0_dst_en, alloc1_req, alloc1_dst_en;
    logic [4:0]       alloc0_dst, alloc1_dst;
    logic             alloc_rdy;
    logic [IDX_W-1:0] alloc0_slot, alloc1_slot;
    logic             fillA_val, fillB_val;
    logic [IDX_W-1:0] fillA_slot, fillB_slot;
    logic [31:0]      fillA_data, fillB_data;
    logic             commit0_val, commit0_wen, commit1_val, commit1_wen;
    logic [4:0]       commit0_waddr, commit1_waddr;
    logic [31:0]      commit0_wdata, commit1_wdata;
    logic [IDX_W:0]   rob_count;
    logic             rob_empty;

    always #5 clk = ~clk;

    riscv_core_reorder_buffer #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset),
        .alloc0_req(alloc0_req), .alloc0_dst_en(alloc0_dst_en), .alloc0_dst(alloc0_dst),
        .alloc1_req(alloc1_req), .alloc1_dst_en(alloc1_dst_en), .alloc1_dst(alloc1_dst),
        .alloc_rdy(alloc_rdy), .alloc0_slot(alloc0_slot), .alloc1_slot(alloc1_slot),
        .fillA_val(fillA_val), .fillA_slot(fillA_slot), .fillA_data(fillA_data),
        .fillB_val(fillB_val), .fillB_slot(fillB_slot), .fillB_data(fillB_data),
        .commit0_val(commit0_val), .commit0_wen(commit0_wen),
        .commit0_waddr(commit0_waddr), .commit0_wdata(commit0_wdata),
        .commit1_val(commit1_val), .commit1_wen(commit1_wen),
        .commit1_waddr(commit1_waddr), .commit1_wdata(commit1_wdata),
        .rob_count(rob_count), .rob_empty(rob_empty)
    );

    // Reference model: live instructions in program order, oldest first
    typedef struct {
        int          slot;
        bit          wen;
        bit [4:0]    waddr;
        bit          done;
        bit [31:0]   data;
    } ent_t;

    ent_t mq[$];
    int   m_tail;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against what the model predicts for this cycle
    task automatic check_all();
        bit c0, c1;
        c0 = (mq.size() > 0) && mq[0].done;
        c1 = c0 && (mq.size() > 1) && mq[1].done;
        chk("alloc_rdy",   32'(alloc_rdy),   32'(mq.size() <= int'(ENTRIES) - 2));
        chk("alloc0_slot", 32'(alloc0_slot), 32'(m_tail));
        chk("alloc1_slot", 32'(alloc1_slot), 32'((m_tail + 1) % int'(ENTRIES)));
        chk("commit0_val", 32'(commit0_val), 32'(c0));
        chk("commit1_val", 32'(commit1_val), 32'(c1));
        chk("commit0_wen", 32'(commit0_wen), c0 ? 32'(mq[0].wen) : 32'd0);
        chk("commit1_wen", 32'(commit1_wen), c1 ? 32'(mq[1].wen) : 32'd0);
        if (c0) begin
            chk("commit0_waddr", 32'(commit0_waddr), 32'(mq[0].waddr));
            chk("commit0_wdata", commit0_wdata, mq[0].data);
        end
        if (c1) begin
            chk("commit1_waddr", 32'(commit1_waddr), 32'(mq[1].waddr));
            chk("commit1_wdata", commit1_wdata, mq[1].data);
        end
        chk("rob_count", 32'(rob_count), 32'(mq.size()));
        chk("rob_empty", 32'(rob_empty), 32'(mq.size() == 0));
    endtask

    task automatic mark_done(input int s, input bit [31:0] d);
        ent_t e;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].slot == s) begin
                e = mq[i];
                e.done = 1'b1;
                e.data = d;
                mq[i] = e;
            end
        end
    endtask

    task automatic push_ent(input bit en, input bit [4:0] dst);
        ent_t e;
        e.slot  = m_tail;
        e.wen   = en && (dst != 5'd0);
        e.waddr = dst;
        e.done  = 1'b0;
        e.data  = '0;
        mq.push_back(e);
        m_tail  = (m_tail + 1) % int'(ENTRIES);
    endtask

    // Apply one clock edge to the model using the inputs currently driven
    task automatic model_edge();
        int  nret;
        bit  rdy;
        if (reset) begin
            mq.delete();
            m_tail = 0;
            return;
        end
        rdy  = (mq.size() <= int'(ENTRIES) - 2);
        nret = 0;
        if (mq.size() > 0 && mq[0].done) begin
            nret = 1;
            if (mq.size() > 1 && mq[1].done) nret = 2;
        end
        if (fillB_val) mark_done(int'(fillB_slot), fillB_data);
        if (fillA_val) mark_done(int'(fillA_slot), fillA_data);
        repeat (nret) void'(mq.pop_front());
        if (rdy && alloc0_req) begin
            push_ent(alloc0_dst_en, alloc0_dst);
            if (alloc1_req) push_ent(alloc1_dst_en, alloc1_dst);
        end
    endtask

    task automatic idle();
        alloc0_req = 0; alloc0_dst_en = 0; alloc0_dst = '0;
        alloc1_req = 0; alloc1_dst_en = 0; alloc1_dst = '0;
        fillA_val = 0; fillA_slot = '0; fillA_data = '0;
        fillB_val = 0; fillB_slot = '0; fillB_data = '0;
    endtask

    task automatic cycle();
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        reset = 1; cycle(); reset = 0;
    endtask

    task automatic alloc2(input logic [4:0] d0, input logic [4:0] d1);
        alloc0_req = 1; alloc0_dst_en = 1; alloc0_dst = d0;
        alloc1_req = 1; alloc1_dst_en = 1; alloc1_dst = d1;
        cycle(); idle();
    endtask

    task automatic alloc1x(input logic [4:0] d0);
        alloc0_req = 1; alloc0_dst_en = 1; alloc0_dst = d0;
        cycle(); idle();
    endtask

    task automatic fill_a(input int s, input logic [31:0] d);
        fillA_val = 1; fillA_slot = IDX_W'(s); fillA_data = d;
        cycle(); idle();
    endtask

    task automatic fill_b(input int s, input logic [31:0] d);
        fillB_val = 1; fillB_slot = IDX_W'(s); fillB_data = d;
        cycle(); idle();
    endtask

    task automatic fill2(input int sa, input logic [31:0] da, input int sb, input logic [31:0] db);
        fillA_val = 1; fillA_slot = IDX_W'(sa); fillA_data = da;
        fillB_val = 1; fillB_slot = IDX_W'(sb); fillB_data = db;
        cycle(); idle();
    endtask

    task automatic rand_fill(output logic v, output logic [IDX_W-1:0] s, output logic [31:0] d);
        int k;
        v = ($urandom_range(0, 2) != 0);
        if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
            k = int'($urandom_range(0, mq.size() - 1));
            s = IDX_W'(mq[k].slot);
        end else begin
            s = IDX_W'($urandom_range(0, ENTRIES - 1));
        end
        d = $urandom();
    endtask

    initial begin
        idle();
        reset = 1;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        reset = 0;

        // Power-on state
        chk("por_alloc0_slot", 32'(alloc0_slot), 32'd0);
        chk("por_alloc1_slot", 32'(alloc1_slot), 32'd1);
        chk("por_rob_empty",   32'(rob_empty),   32'd1);

        // Dual alloc, younger completes first
        alloc2(5'd5, 5'd6);
        fill_b(1, 32'h22);
        chk("rev_c0_blocked", 32'(commit0_val), 32'd0);
        fill_a(0, 32'h11);
        chk("rev_c0_val",   32'(commit0_val),   32'd1);
        chk("rev_c0_waddr", 32'(commit0_waddr), 32'd5);
        chk("rev_c0_wdata", commit0_wdata,      32'h11);
        chk("rev_c1_val",   32'(commit1_val),   32'd1);
        chk("rev_c1_waddr", 32'(commit1_waddr), 32'd6);
        chk("rev_c1_wdata", commit1_wdata,      32'h22);
        cycle();
        chk("rev_empty", 32'(rob_empty), 32'd1);

        // Head blocking: only the youngest of three completes
        do_reset();
        alloc2(5'd1, 5'd2);
        alloc1x(5'd3);
        fill_a(2, 32'h33);
        for (int i = 0; i < 10; i++) begin
            chk("blk_c0_val", 32'(commit0_val), 32'd0);
            chk("blk_count",  32'(rob_count),   32'd3);
            cycle();
        end
        fill2(0, 32'hA0, 1, 32'hB1);
        run(3);
        chk("blk_drained", 32'(rob_empty), 32'd1);

        // Reset with five live entries
        do_reset();
        alloc2(5'd8, 5'd9);
        alloc2(5'd10, 5'd11);
        alloc1x(5'd12);
        fill_a(4, 32'h44);
        do_reset();
        chk("rst_count", 32'(rob_count),   32'd0);
        chk("rst_empty", 32'(rob_empty),   32'd1);
        chk("rst_rdy",   32'(alloc_rdy),   32'd1);
        chk("rst_c0",    32'(commit0_val), 32'd0);
        fill_a(2, 32'h55);
        chk("rst_stale_c0",    32'(commit0_val), 32'd0);
        chk("rst_stale_count", 32'(rob_count),   32'd0);

        // Full boundary
        for (int i = 0; i < 7; i++) alloc2(5'(2 * i + 1), 5'(2 * i + 2));
        chk("full14_count", 32'(rob_count), 32'd14);
        chk("full14_rdy",   32'(alloc_rdy), 32'd1);
        alloc2(5'd20, 5'd21);
        chk("full16_count", 32'(rob_count), 32'd16);
        chk("full16_rdy",   32'(alloc_rdy), 32'd0);
        alloc2(5'd22, 5'd23);
        chk("full_ign_count", 32'(rob_count),   32'd16);
        chk("full_ign_tail",  32'(alloc0_slot), 32'd0);

        // Wrap-around: walk head and tail to 15, then dual alloc across the seam
        do_reset();
        for (int i = 0; i < 7; i++) alloc2(5'(i + 1), 5'(i + 2));
        alloc1x(5'd30);
        for (int i = 0; i < 7; i++) fill2(2 * i, 32'(i + 100), 2 * i + 1, 32'(i + 200));
        fill_a(14, 32'hE0);
        run(10);
        chk("wrap_tail15", 32'(alloc0_slot), 32'd15);
        chk("wrap_next0",  32'(alloc1_slot), 32'd0);
        alloc2(5'd9, 5'd10);
        fill2(15, 32'hF15, 0, 32'hF00);
        chk("wrap_c0_val",   32'(commit0_val),   32'd1);
        chk("wrap_c1_val",   32'(commit1_val),   32'd1);
        chk("wrap_c0_wdata", commit0_wdata,      32'hF15);
        chk("wrap_c1_wdata", commit1_wdata,      32'hF00);
        cycle();
        chk("wrap_count", 32'(rob_count),   32'd0);
        chk("wrap_head1", 32'(alloc0_slot), 32'd1);

        // Entries that do not write the register file
        alloc0_req = 1; alloc0_dst_en = 0; alloc0_dst = 5'd7;
        alloc1_req = 1; alloc1_dst_en = 1; alloc1_dst = 5'd0;
        cycle(); idle();
        fill2(1, 32'h77, 2, 32'h88);
        chk("nw_c0_val", 32'(commit0_val), 32'd1);
        chk("nw_c1_val", 32'(commit1_val), 32'd1);
        chk("nw_c0_wen", 32'(commit0_wen), 32'd0);
        chk("nw_c1_wen", 32'(commit1_wen), 32'd0);
        cycle();

        // Random traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic             v;
            logic [IDX_W-1:0] s;
            logic [31:0]      d;
            reset         = ($urandom_range(0, 149) == 0);
            alloc0_req    = ($urandom_range(0, 3) != 0);
            alloc1_req    = ($urandom_range(0, 1) != 0);
            alloc0_dst_en = ($urandom_range(0, 4) != 0);
            alloc1_dst_en = ($urandom_range(0, 4) != 0);
            alloc0_dst    = 5'($urandom_range(0, 31));
            alloc1_dst    = 5'($urandom_range(0, 31));
            rand_fill(v, s, d);
            fillA_val = v; fillA_slot = s; fillA_data = d;
            rand_fill(v, s, d);
            fillB_val = v; fillB_slot = s; fillB_data = d;
            if ($urandom_range(0, 9) == 0) fillB_slot = fillA_slot;
            cycle();
        end
        reset = 0;
        idle();
        run(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
